// File: rtl/mult_datapath_if.sv
// rtl/mult_datapath_if.sv - sequencer <-> multiplier datapath control/status bundle
interface mult_datapath_if;
  logic [7:0] sw;
  logic       clear_Ld;
  logic       LoadA;
  logic       fn;
  logic       shift;
  logic       M;
  logic       X;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic [3:0] shift_cnt;
  logic       cnt_done;

  modport master (
    output sw, clear_Ld, LoadA, fn, shift,
    input  M, X, Aval, Bval, shift_cnt, cnt_done
  );

  modport slave (
    input  sw, clear_Ld, LoadA, fn, shift,
    output M, X, Aval, Bval, shift_cnt, cnt_done
  );
endinterface

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - signed shift-add multiplier datapath (X/A/B registers, 9-bit adder, optional shift counter via MULT_DP_SHIFT_CNT_EN)
module mult_datapath (
  input  logic           clk,
  input  logic           reset_n,
  mult_datapath_if.slave bus
);

  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       x_q;
  logic [8:0] sum;

  // Sign-extend both operands to 9 bits so X captures the true sign of A +/- S
  always_comb begin
    sum = 9'd0;
    if (bus.fn) begin
      sum = {a_q[7], a_q} - {bus.sw[7], bus.sw};
    end else begin
      sum = {a_q[7], a_q} + {bus.sw[7], bus.sw};
    end
  end

  // Product registers: clear_Ld beats LoadA beats shift; otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= 1'b0;
      a_q <= 8'h00;
      b_q <= 8'h00;
    end else if (bus.clear_Ld) begin
      x_q <= 1'b0;
      a_q <= 8'h00;
      b_q <= bus.sw;
    end else if (bus.LoadA) begin
      x_q <= sum[8];
      a_q <= sum[7:0];
    end else if (bus.shift) begin
      a_q <= {x_q, a_q[7:1]};
      b_q <= {a_q[0], b_q[7:1]};
    end
  end

  assign bus.X    = x_q;
  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.M    = b_q[0];

`ifdef MULT_DP_SHIFT_CNT_EN
  logic [3:0] cnt_q;

  // Shift counter: cleared with the product, frozen when a load steals the cycle, saturates at 8
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else if (bus.clear_Ld) begin
      cnt_q <= 4'd0;
    end else if (!bus.LoadA && bus.shift && (cnt_q != 4'd8)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign bus.shift_cnt = cnt_q;
  assign bus.cnt_done  = (cnt_q == 4'd8);
`else
  assign bus.shift_cnt = 4'd0;
  assign bus.cnt_done  = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - scoreboard bench for mult_datapath
module tb_mult_datapath;

  logic clk;
  logic reset_n;

  mult_datapath_if bus ();

  mult_datapath dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       x;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int n_checks;
  int n_fail;

  logic       m_x;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [3:0] m_cnt;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_cnt(input logic [3:0] c);
`ifdef MULT_DP_SHIFT_CNT_EN
    return c;
`else
    return 4'd0 & c;
`endif
  endfunction

  task automatic set_idle();
    bus.clear_Ld = 1'b0;
    bus.LoadA    = 1'b0;
    bus.fn       = 1'b0;
    bus.shift    = 1'b0;
  endtask

  task automatic sb_compare();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      check("sb_empty", 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".X"}, {15'd0, bus.X}, {15'd0, e.x});
      check({t, ".A"}, {8'd0, bus.Aval}, {8'd0, e.a});
      check({t, ".B"}, {8'd0, bus.Bval}, {8'd0, e.b});
      check({t, ".M"}, {15'd0, bus.M}, {15'd0, e.b[0]});
      check({t, ".cnt"}, {12'd0, bus.shift_cnt}, {12'd0, exp_cnt(e.cnt)});
      check({t, ".done"}, {15'd0, bus.cnt_done}, {15'd0, (exp_cnt(e.cnt) == 4'd8)});
    end
  endtask

  // Drive one cycle, advance the reference model, push its prediction, then compare after the edge
  task automatic step(input string tag, input logic clr, input logic ld, input logic f,
                      input logic sh, input logic [7:0] s);
    exp_t       e;
    logic [8:0] s9;
    @(negedge clk);
    bus.clear_Ld = clr;
    bus.LoadA    = ld;
    bus.fn       = f;
    bus.shift    = sh;
    bus.sw       = s;
    if (clr) begin
      m_x = 1'b0; m_a = 8'h00; m_b = s; m_cnt = 4'd0;
    end else if (ld) begin
      s9  = f ? ({m_a[7], m_a} - {s[7], s}) : ({m_a[7], m_a} + {s[7], s});
      m_x = s9[8];
      m_a = s9[7:0];
    end else if (sh) begin
      m_b = {m_a[0], m_b[7:1]};
      m_a = {m_x, m_a[7:1]};
      if (m_cnt != 4'd8) m_cnt = m_cnt + 4'd1;
    end
    e.x = m_x; e.a = m_a; e.b = m_b; e.cnt = m_cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    set_idle();
    sb_compare();
  endtask

  task automatic run_mult(input string tag, input logic [7:0] b, input logic [7:0] s,
                          input logic [15:0] prod);
    logic signed [7:0] bs;
    logic signed [7:0] ss;
    int                ref_p;
    bs    = b;
    ss    = s;
    ref_p = int'(bs) * int'(ss);
    step({tag, ".clr"}, 1'b1, 1'b0, 1'b0, 1'b0, b);
    for (int i = 0; i < 8; i++) begin
      if (m_b[0]) step({tag, ".ld"}, 1'b0, 1'b1, (i == 7), 1'b0, s);
      step({tag, ".sh"}, 1'b0, 1'b0, 1'b0, 1'b1, s);
    end
    check({tag, ".prod"}, {bus.Aval, bus.Bval}, prod);
    check({tag, ".ref"}, {bus.Aval, bus.Bval}, ref_p[15:0]);
  endtask

  // Assert reset between edges, verify it acts without a clock, hold it against busy inputs, release
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check({tag, ".async.X"}, {15'd0, bus.X}, 16'd0);
    check({tag, ".async.A"}, {8'd0, bus.Aval}, 16'd0);
    check({tag, ".async.B"}, {8'd0, bus.Bval}, 16'd0);
    check({tag, ".async.M"}, {15'd0, bus.M}, 16'd0);
    check({tag, ".async.cnt"}, {12'd0, bus.shift_cnt}, 16'd0);
    check({tag, ".async.done"}, {15'd0, bus.cnt_done}, 16'd0);
    m_x = 1'b0; m_a = 8'h00; m_b = 8'h00; m_cnt = 4'd0;
    bus.clear_Ld = 1'b1;
    bus.LoadA    = 1'b1;
    bus.sw       = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".held.A"}, {8'd0, bus.Aval}, 16'd0);
    check({tag, ".held.B"}, {8'd0, bus.Bval}, 16'd0);
    set_idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.sw   = 8'h00;
    set_idle();
    m_x = 1'b0; m_a = 8'h00; m_b = 8'h00; m_cnt = 4'd0;

    #1;
    check("rst.A", {8'd0, bus.Aval}, 16'd0);
    check("rst.B", {8'd0, bus.Bval}, 16'd0);
    check("rst.X", {15'd0, bus.X}, 16'd0);
    check("rst.cnt", {12'd0, bus.shift_cnt}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // First edge after release honours clear_Ld
    step("first", 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    check("first.B", {8'd0, bus.Bval}, 16'h003C);

    // Add then shift
    step("add.clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    step("add.ld", 1'b0, 1'b1, 1'b0, 1'b0, 8'h07);
    check("add.X", {15'd0, bus.X}, 16'd0);
    check("add.A", {8'd0, bus.Aval}, 16'h0007);
    step("add.sh", 1'b0, 1'b0, 1'b0, 1'b1, 8'h07);
    check("add.sh.A", {8'd0, bus.Aval}, 16'h0003);
    check("add.sh.B", {8'd0, bus.Bval}, 16'h0081);
    check("add.sh.M", {15'd0, bus.M}, 16'd1);

    // Subtract into negative, shift preserves sign via X
    step("sub.clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step("sub.ld", 1'b0, 1'b1, 1'b1, 1'b0, 8'h05);
    check("sub.X", {15'd0, bus.X}, 16'd1);
    check("sub.A", {8'd0, bus.Aval}, 16'h00FB);
    step("sub.sh", 1'b0, 1'b0, 1'b1, 1'b1, 8'h05);
    check("sub.sh.A", {8'd0, bus.Aval}, 16'h00FD);
    check("sub.sh.X", {15'd0, bus.X}, 16'd1);
    check("sub.sh.B7", {15'd0, bus.Bval[7]}, 16'd1);

    // Full multiplications
    run_mult("m3xfe", 8'h03, 8'hFE, 16'hFFFA);
    run_mult("m7fx7f", 8'h7F, 8'h7F, 16'h3F01);
    run_mult("m80x80", 8'h80, 8'h80, 16'h4000);
    run_mult("m81x05", 8'h81, 8'h05, 16'hFD85);

    // LoadA with shift: load wins, counter frozen
    step("prio.clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
    step("prio.sh", 1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    step("prio.ldsh", 1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
    check("prio.ldsh.A", {8'd0, bus.Aval}, 16'h0022);
    check("prio.ldsh.B", {8'd0, bus.Bval}, 16'h0008);
`ifdef MULT_DP_SHIFT_CNT_EN
    check("prio.ldsh.cnt", {12'd0, bus.shift_cnt}, 16'd1);
`else
    check("prio.ldsh.cnt", {12'd0, bus.shift_cnt}, 16'd0);
`endif
    step("prio.clrld", 1'b1, 1'b1, 1'b1, 1'b1, 8'h44);
    check("prio.clrld.A", {8'd0, bus.Aval}, 16'h0000);
    check("prio.clrld.B", {8'd0, bus.Bval}, 16'h0044);

    // Counter saturation
    step("sat.clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    for (int i = 0; i < 9; i++) step("sat.sh", 1'b0, 1'b0, 1'b0, 1'b1, 8'(i));
`ifdef MULT_DP_SHIFT_CNT_EN
    check("sat.cnt", {12'd0, bus.shift_cnt}, 16'd8);
    check("sat.done", {15'd0, bus.cnt_done}, 16'd1);
`else
    check("sat.cnt", {12'd0, bus.shift_cnt}, 16'd0);
    check("sat.done", {15'd0, bus.cnt_done}, 16'd0);
`endif
    step("sat.clr2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("sat.clr2.cnt", {12'd0, bus.shift_cnt}, 16'd0);

    // Random traffic, including sw/fn changes on non-load cycles
    for (int i = 0; i < 60; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      step("rnd", (r == 4'd0), r[1], r[2], r[3], 8'($urandom));
    end

    // Reset in the middle of a multiplication
    step("mid.clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F);
    step("mid.ld", 1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
    step("mid.sh", 1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
    do_reset("mid");
    step("mid.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
    step("mid.sh2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
    run_mult("post", 8'hF6, 8'h0C, 16'hFF88);

    if (exp_q.size() != 0) check("sb_leftover", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 sw  input  8  switch value: multiplier when loading B, signed multiplicand S at all other times.
REQ-005 clear_Ld  input  1  clear A and X, load B from sw.
REQ-006 LoadA  input  1  load adder result into X and A.
REQ-007 fn  input  1  adder function: 0 = add S, 1 = subtract S.
REQ-008 shift  input  1  arithmetic right shift of {X,A,B}.
REQ-009 M  output  1  multiplier LSB, equal to B[0], returned to the sequencer.
REQ-010 X  output  1  sign-extension bit.
REQ-011 Aval  output  8  register A, the product high byte.
REQ-012 Bval  output  8  register B, the product low byte.
REQ-013 shift_cnt  output  4  count of shifts since the last clear.
REQ-014 cnt_done  output  1  high when shift_cnt equals 8.

Function
REQ-015 All register updates SHALL occur on the rising clk edge; M, Aval, Bval and X SHALL be driven directly from registers with no combinational input-to-output path.
REQ-016 Per-cycle priority SHALL be: clear_Ld, then LoadA, then shift, then hold.
REQ-017 On a clear_Ld cycle: A <= 0, X <= 0, B <= sw, shift_cnt <= 0; LoadA and shift are ignored.
REQ-018 Adder: 9-bit two's complement; sum = {A[7],A} + {sw[7],sw} when fn=0, and {A[7],A} - {sw[7],sw} when fn=1, modulo 2^9.
REQ-019 On a LoadA cycle without clear_Ld: X <= sum[8], A <= sum[7:0], B unchanged.
REQ-020 If LoadA and shift are both high, LoadA SHALL win, the shift SHALL be dropped, and shift_cnt SHALL NOT change.
REQ-021 On a shift-only cycle: X unchanged, A <= {X, A[7:1]}, B <= {A[0], B[7:1]}.
REQ-022 On a shift-only cycle, shift_cnt SHALL increment and saturate at 8.
REQ-023 fn SHALL have no effect on any cycle in which LoadA is low.
REQ-024 M SHALL reflect the new B[0] in the cycle after any B update.
REQ-025 After the sequence clear_Ld, then 8 iterations of (optional LoadA, then shift) with fn=1 only on the 8th LoadA, {A,B} SHALL equal the signed 16-bit product of the original B and S.
REQ-026 sw changes on non-load cycles SHALL affect only the adder result.

Reset
REQ-027 While reset_n=0: X=0, A=0x00, B=0x00, M=0, shift_cnt=0, cnt_done=0, asynchronously and regardless of clk.
REQ-028 Reset deasserting mid-multiplication SHALL leave all state zero; no partial product is retained.
REQ-029 In the first edge after reset release, control inputs SHALL be honoured normally.

Configuration
REQ-030 Macro MULT_DP_SHIFT_CNT_EN defined: shift_cnt and cnt_done SHALL be implemented per REQ-013, REQ-014, REQ-017, REQ-020 and REQ-022.
REQ-031 Macro MULT_DP_SHIFT_CNT_EN undefined: shift_cnt SHALL be tied to 0 and cnt_done to 0, with no counter flops; all other behaviour is unchanged.

Verification
REQ-032 The bench SHALL cover: reset_n=0 with A,B preloaded -> A=B=0, X=0, M=0 immediately, without a clock edge.
REQ-033 The bench SHALL cover: clear_Ld with sw=0x03, then sw=0x07 with LoadA and fn=0 -> X=0, A=0x07; then shift -> A=0x03, B=0x81, M=1.
REQ-034 The bench SHALL cover: A=0, X=0, sw=0x05, LoadA with fn=1 -> X=1, A=0xFB; then shift -> A=0xFD, X=1, B[7]=1.
REQ-035 The bench SHALL cover: the full sequence with B=0x03 and S=0xFE -> {A,B}=0xFFFA; with B=0x7F and S=0x7F -> 0x3F01; with B=0x80 and S=0x80 -> 0x4000.
REQ-036 The bench SHALL cover: LoadA and shift high together -> only the load is applied and shift_cnt is unchanged; clear_Ld together with LoadA -> clear wins.
REQ-037 The bench SHALL cover, with MULT_DP_SHIFT_CNT_EN defined: 9 shifts -> shift_cnt=8 and cnt_done=1; then clear_Ld -> shift_cnt=0. With the macro undefined: shift_cnt=0 throughout.
